// File: rtl/preload_sequencer_pkg.sv
// preload_sequencer_pkg: shared lookup types used by the preload path
package preload_sequencer_pkg;
  typedef logic [31:0] node_t;
  typedef logic [15:0] ptr_t;
  typedef enum logic [2:0] {IDLE, CLA, PTR, NXT, FIN} PRELOAD_STATE_t;
endpackage

// File: rtl/preload_rd_stage.sv
// preload_rd_stage: aligns memory read enables and the change-engine flag with the returned data
module preload_rd_stage
  import preload_sequencer_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  cla_rd_en,
  input  logic  ptr_rd_en,
  input  logic  chg_in,
  input  node_t cla_rd_data,
  input  ptr_t  ptr_rd_data,
  output node_t clause_out,
  output logic  load_clause_out,
  output ptr_t  ptr_out,
  output logic  load_ptr_out,
  output logic  load_change_engine_out
);
  always_ff @(posedge clock) begin
    if (reset) begin
      load_clause_out <= 1'b0;
      load_ptr_out <= 1'b0;
      load_change_engine_out <= 1'b0;
    end else begin
      load_clause_out <= cla_rd_en;
      load_ptr_out <= ptr_rd_en;
      load_change_engine_out <= chg_in;
    end
  end
  // memories are already synchronous, so data only needs masking to the valid cycle
  always_comb begin
    clause_out = load_clause_out ? cla_rd_data : '0;
    ptr_out = load_ptr_out ? ptr_rd_data : '0;
  end
endmodule

// File: rtl/preload_sequencer.sv
// preload_sequencer: walks all engines, reading clauses then pointers into the latency buffer load path
module preload_sequencer
  import preload_sequencer_pkg::*;
#(
  parameter int NUM_ENGINE = 4,
  parameter int LIT_IDX_MAX = 16,
  parameter int CLA_ADDR_W = 16,
  parameter int PTR_ADDR_W = $clog2(NUM_ENGINE * 2 * LIT_IDX_MAX)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             pause,
  input  logic [NUM_ENGINE*CLA_ADDR_W-1:0] num_clauses,
  output logic                             cla_rd_en,
  output logic [CLA_ADDR_W-1:0]            cla_rd_addr,
  input  node_t                            cla_rd_data,
  output logic                             ptr_rd_en,
  output logic [PTR_ADDR_W-1:0]            ptr_rd_addr,
  input  ptr_t                             ptr_rd_data,
  output node_t                            clause_out,
  output logic                             load_clause_out,
  output ptr_t                             ptr_out,
  output logic                             load_ptr_out,
  output logic                             load_change_engine_out,
  output logic                             busy,
  output logic                             done
);
  localparam int ENG_W = $clog2(NUM_ENGINE);
  localparam int PTR_N = 2 * LIT_IDX_MAX;
  localparam int PI_W = PTR_N > 1 ? $clog2(PTR_N) : 1;
  PRELOAD_STATE_t state;
  logic [NUM_ENGINE*CLA_ADDR_W-1:0] counts;
  logic [ENG_W-1:0] eng;
  logic [CLA_ADDR_W-1:0] cla_addr, cla_idx, cur_count;
  logic [PI_W-1:0] ptr_idx;
  logic chg_pending, chg_in;
  // the change flag rides with the first clause read, or alone from the zero-count CLA cycle
  always_comb begin
    cur_count = counts[eng*CLA_ADDR_W +: CLA_ADDR_W];
    cla_rd_en = state == CLA && !pause && cla_idx < cur_count;
    cla_rd_addr = cla_addr;
    ptr_rd_en = state == PTR && !pause;
    ptr_rd_addr = PTR_ADDR_W'(eng) * PTR_ADDR_W'(PTR_N) + PTR_ADDR_W'(ptr_idx);
    chg_in = chg_pending && state == CLA && !pause;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      counts <= '0;
      eng <= '0;
      cla_addr <= '0;
      cla_idx <= '0;
      ptr_idx <= '0;
      chg_pending <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (chg_in) chg_pending <= 1'b0;
      if (cla_rd_en) begin
        cla_addr <= cla_addr + CLA_ADDR_W'(1);
        cla_idx <= cla_idx + CLA_ADDR_W'(1);
      end
      if (ptr_rd_en) ptr_idx <= ptr_idx + PI_W'(1);
      case (state)
        IDLE: if (start && !done) begin
          counts <= num_clauses;
          eng <= '0;
          cla_addr <= '0;
          cla_idx <= '0;
          ptr_idx <= '0;
          busy <= 1'b1;
          state <= CLA;
        end
        CLA: if (!pause && cla_idx + CLA_ADDR_W'(1) >= cur_count) state <= PTR;
        PTR: if (ptr_rd_en && ptr_idx == PI_W'(PTR_N - 1))
          state <= eng == ENG_W'(NUM_ENGINE - 1) ? FIN : NXT;
        NXT: begin
          eng <= eng + ENG_W'(1);
          cla_idx <= '0;
          ptr_idx <= '0;
          chg_pending <= 1'b1;
          state <= CLA;
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  preload_rd_stage u_rd_stage (
    .clock(clock),
    .reset(reset),
    .cla_rd_en(cla_rd_en),
    .ptr_rd_en(ptr_rd_en),
    .chg_in(chg_in),
    .cla_rd_data(cla_rd_data),
    .ptr_rd_data(ptr_rd_data),
    .clause_out(clause_out),
    .load_clause_out(load_clause_out),
    .ptr_out(ptr_out),
    .load_ptr_out(load_ptr_out),
    .load_change_engine_out(load_change_engine_out)
  );
endmodule
